bcd2bin_iter: RTL



---
 rtl/bcd2bin_iter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bcd2bin_iter.sv
// Iterative packed-BCD to unsigned binary converter: folds one digit per cycle,
// most-significant digit first, behind val/rdy handshakes on both sides.
module bcd2bin_iter #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [4*NDIGITS-1:0]   in_,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [4*NDIGITS-1:0]   out,
  output logic                   out_err
);

  localparam int W  = 4 * NDIGITS;
  localparam int WE = W + 4;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            in_rdy_q, in_rdy_d;
  logic            out_val_q, out_val_d;
  logic [W-1:0]    out_q, out_d;
  logic            out_err_q, out_err_d;
  logic [3:0]      digit_s;
  logic [WE-1:0]   acc_ext_s;

  function automatic logic digit_bad(input logic [3:0] d);
    return (d > 4'd9);
  endfunction

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    in_rdy_d  = in_rdy_q;
    out_val_d = out_val_q;
    out_d     = out_q;
    out_err_d = out_err_q;

    // The shadow shifts left each step, so the current digit is always on top.
    digit_s   = shadow_q[W-1 -: 4];
    acc_ext_s = ({4'd0, acc_q} << 3) + ({4'd0, acc_q} << 1) + {{(WE-4){1'b0}}, digit_s};

    case (state_q)
      IDLE: begin
        if (in_val) begin
          shadow_d = in_;
          acc_d    = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
          in_rdy_d = 1'b0;
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        acc_d    = acc_ext_s[W-1:0];
        err_d    = err_q | digit_bad(digit_s);
        shadow_d = shadow_q << 4;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          state_d   = DONE;
          out_val_d = 1'b1;
          out_d     = err_d ? '0 : acc_d;
          out_err_d = err_d;
        end else begin
          state_d   = CALC;
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_d   = IDLE;
          out_val_d = 1'b0;
          out_d     = '0;
          out_err_d = 1'b0;
          in_rdy_d  = 1'b1;
        end else begin
          state_d   = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        out_val_d = 1'b0;
        out_d     = '0;
        out_err_d = 1'b0;
        in_rdy_d  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
      out_q     <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
      out_q     <= out_d;
      out_err_q <= out_err_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_val = out_val_q;
  assign out     = out_q;
  assign out_err = out_err_q;

endmodule
